// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and the
// default counter width and load modulus.
package countdown_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_MODULUS = 100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/load_clamp.sv
// Combinational load-value limiter: value = min(data, MODULUS).
// Shared with the up-counter's load path.
module load_clamp
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned MODULUS = DEF_MODULUS
) (
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MODULUS);

  // Saturate anything above the modulus
  always_comb begin
    if (data > LIMIT) begin
      value = LIMIT;
    end else begin
      value = data;
    end
  end

endmodule

// File: rtl/countdown_timer_8bit.sv
// Loadable down-counter with start/stop, one-cycle terminal-count pulse and
// busy/done flags. Define COUNTDOWN_AUTO_RELOAD_EN for periodic auto-reload.
module countdown_timer_8bit
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned MODULUS = DEF_MODULUS
) (
  input  logic             clock,
  input  logic             sclr,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] load_value;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload;
`endif

  load_clamp #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_load_clamp (
    .data  (data),
    .value (load_value)
  );

  // FSM and datapath; priority within a cycle is sclr > stop > start > count
  always_ff @(posedge clock) begin
    if (sclr) begin
      state <= ST_IDLE;
      q     <= ZERO;
      tc    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload <= ZERO;
`endif
    end else begin
      tc <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          // stop has nothing to abort here, but still suppresses a coincident start
          if (start && !stop) begin
            state <= ST_RUN;
            q     <= load_value;
            busy  <= 1'b1;
            done  <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload <= load_value;
`endif
          end else begin
            state <= state;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (start) begin
            q <= load_value;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload <= load_value;
`endif
          end else if (en) begin
            if (q == ZERO) begin
              tc <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              q <= reload;
`else
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
`endif
            end else begin
              q <= q - ONE;
            end
          end else begin
            q <= q;
          end
        end
        default: begin
          state <= ST_IDLE;
          q     <= ZERO;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
